// File: rtl/alu_pipe.sv
// Handshaked, registered ALU with flags and shifts; an iterative shift-add
// multiplier is added when ALU_MUL_EN is defined.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       csig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             c,
    output logic             n,
    output logic             v
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1
`ifdef ALU_MUL_EN
        , BUSY = 2'd2
`endif
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             load_alu;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH:0]   sll_w;
    logic [WIDTH:0]   srl_w;
    logic [WIDTH:0]   sra_w;

    // Valid/ready: a transfer happens on any edge where valid and ready are both high;
    // the producer holds its data until then, the consumer may drop ready at any time.
    assign in_ready = !rst && ((state == IDLE) || (state == HOLD && out_ready));
    assign accept   = in_valid && in_ready;

    // Shifts run one bit wider so the last bit shifted out lands in the extra position.
    always_comb begin
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        sh      = b[SHW-1:0];
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        sll_w   = {1'b0, a} << sh;
        srl_w   = {a, 1'b0} >> sh;
        sra_w   = $signed({a, 1'b0}) >>> sh;
        case (csig)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_ADD: begin
                res   = add_sum[WIDTH-1:0];
                res_c = add_sum[WIDTH];
                res_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = sub_sum[WIDTH-1:0];
                res_c = sub_sum[WIDTH];
                res_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL: begin
                res   = sll_w[WIDTH-1:0];
                res_c = sll_w[WIDTH];
            end
            OP_SRL: begin
                res   = srl_w[WIDTH:1];
                res_c = srl_w[0];
            end
            OP_SRA: begin
                res   = sra_w[WIDTH:1];
                res_c = sra_w[0];
            end
            default: res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0]   OP_MUL   = 4'b1100;
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

    logic                 start_mul;
    logic                 step_mul;
    logic                 done_mul;
    logic [SHW:0]         cnt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH:0]       mul_sum;

    // Upper half accumulates, lower half starts as the multiplier and shifts out one bit per step.
    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            prod  <= '0;
            mcand <= '0;
        end else if (start_mul) begin
            cnt   <= '0;
            prod  <= {{WIDTH{1'b0}}, b};
            mcand <= a;
        end else if (step_mul) begin
            cnt  <= cnt + {{SHW{1'b0}}, 1'b1};
            prod <= {mul_sum, prod[WIDTH-1:1]};
        end
    end
`endif

    always_comb begin
        state_next = state;
        load_alu   = 1'b0;
`ifdef ALU_MUL_EN
        start_mul  = 1'b0;
        step_mul   = 1'b0;
        done_mul   = 1'b0;
`endif
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (csig == OP_MUL) begin
                        start_mul  = 1'b1;
                        state_next = BUSY;
                    end else
`endif
                    begin
                        load_alu   = 1'b1;
                        state_next = HOLD;
                    end
                end else if (state == HOLD && out_ready) begin
                    state_next = IDLE;
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                if (cnt == CNT_LAST) begin
                    done_mul   = 1'b1;
                    state_next = HOLD;
                end else begin
                    step_mul = 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            z         <= 1'b0;
            c         <= 1'b0;
            n         <= 1'b0;
            v         <= 1'b0;
        end else begin
            state <= state_next;
            if (load_alu) begin
                out       <= res;
                z         <= (res == '0);
                c         <= res_c;
                n         <= res[WIDTH-1];
                v         <= res_v;
                out_valid <= 1'b1;
            end
`ifdef ALU_MUL_EN
            else if (start_mul) begin
                out_valid <= 1'b0;
            end else if (done_mul) begin
                out       <= prod[WIDTH-1:0];
                z         <= (prod[WIDTH-1:0] == '0);
                c         <= |prod[2*WIDTH-1:WIDTH];
                n         <= prod[WIDTH-1];
                v         <= 1'b0;
                out_valid <= 1'b1;
            end
`endif
            else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: transaction-level reference model with a cycle compare process,
// literal checks for the documented cases, then randomized traffic.
module tb_alu_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   csig;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         z;
    logic         c;
    logic         n;
    logic         v;

    int total = 0;
    int bad   = 0;

    // expected {out, z, c, n, v} in acceptance order
    logic [W+3:0] exp_q[$];
    bit           m_valid = 1'b0;
    bit           m_zero  = 1'b0;
    bit           armed   = 1'b0;
    int           m_left  = 0;
    logic [3:0]   ops[16];

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .csig(csig), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .z(z), .c(c), .n(n), .v(v)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic bit is_mul(input logic [3:0] op);
`ifdef ALU_MUL_EN
        return op == 4'b1100;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [W+3:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [3:0] op);
        logic [W-1:0] r;
        logic         cc;
        logic         vv;
        longint       s;
        logic [63:0]  p;
        int           sh;
        r  = '0;
        cc = 1'b0;
        vv = 1'b0;
        sh = int'(y[4:0]);
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0011: r = x ^ y;
            4'b0100: r = ~(x | y);
            4'b0010: begin
                r  = x + y;
                p  = {32'b0, x} + {32'b0, y};
                cc = p > 64'hFFFF_FFFF;
                s  = longint'($signed(x)) + longint'($signed(y));
                vv = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                r  = x - y;
                cc = x >= y;
                s  = longint'($signed(x)) - longint'($signed(y));
                vv = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1000: r = (x < y) ? 32'd1 : 32'd0;
            4'b1001: begin
                r  = x << sh;
                cc = (sh == 0) ? 1'b0 : x[W-sh];
            end
            4'b1010: begin
                r  = x >> sh;
                cc = (sh == 0) ? 1'b0 : x[sh-1];
            end
            4'b1011: begin
                r  = $unsigned($signed(x) >>> sh);
                cc = (sh == 0) ? 1'b0 : x[sh-1];
            end
`ifdef ALU_MUL_EN
            4'b1100: begin
                p  = {32'b0, x} * {32'b0, y};
                r  = p[31:0];
                cc = |p[63:32];
            end
`endif
            default: r = '0;
        endcase
        return {r, (r == '0), cc, r[W-1], vv};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not occur within its cycle bound", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference model: advances once per edge from the inputs seen at that edge
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                m_valid = 1'b0;
                m_left  = 0;
                m_zero  = 1'b1;
                armed   = 1'b1;
            end else if (armed) begin
                bit rdy;
                rdy = (m_left == 0) && (!m_valid || out_ready);
                if (m_valid && out_ready) begin
                    void'(exp_q.pop_front());
                    m_valid = 1'b0;
                end
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_valid = 1'b1;
                        m_zero  = 1'b0;
                    end
                end else if (in_valid && rdy) begin
                    exp_q.push_back(ref_op(a, b, csig));
                    if (is_mul(csig)) begin
                        m_left = W + 1;
                    end else begin
                        m_valid = 1'b1;
                        m_zero  = 1'b0;
                    end
                end
            end
        end
    end

    // scoreboard compare, every cycle on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("in_ready", in_ready, !rst && (m_left == 0) && (!m_valid || out_ready));
                chk("out_valid", out_valid, m_valid);
                if (m_valid && exp_q.size() > 0)
                    chk("result", {out, z, c, n, v}, exp_q[0]);
                else if (m_zero)
                    chk("reset_state", {out, z, c, n, v}, '0);
            end
        end
    end

    // driver: issue one op with out_ready high and check the result against a literal
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op,
                         input logic [W+3:0] want, input string name);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        csig      = op;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && !in_ready; i++) tick();
        if (!in_ready) timeout_fail({name, "_accept"});
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 60 && !out_valid; i++) tick();
        if (!out_valid) timeout_fail({name, "_result"});
        chk(name, {out, z, c, n, v}, want);
    endtask

    initial begin
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1000,
                4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b0101, 4'b1101, 4'b1110, 4'b1111};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; csig = 4'b0000;
        tick(); tick();
        rst = 1'b0;
        tick();

        // literal cases: {out, z, c, n, v}
        do_op(32'h7FFFFFFF, 32'h1, 4'b0010, {32'h80000000, 4'b0011}, "add_ovf");
        do_op(32'hFFFFFFFF, 32'h1, 4'b0010, {32'h00000000, 4'b1100}, "add_carry");
        do_op(32'h5, 32'h7, 4'b0110, {32'hFFFFFFFE, 4'b0010}, "sub_borrow");
        do_op(32'hFFFFFFFF, 32'h1, 4'b0111, {32'h00000001, 4'b0000}, "slt");
        do_op(32'hFFFFFFFF, 32'h1, 4'b1000, {32'h00000000, 4'b1000}, "sltu");
        do_op(32'h80000001, 32'h1, 4'b1011, {32'hC0000000, 4'b0110}, "sra");
        do_op(32'h80000001, 32'h1, 4'b1010, {32'h40000000, 4'b0100}, "srl");
        do_op(32'h80000001, 32'h1, 4'b1001, {32'h00000002, 4'b0100}, "sll");
        do_op(32'h80000001, 32'h0, 4'b1001, {32'h80000001, 4'b0010}, "sll_zero");
        do_op(32'h12345678, 32'h9, 4'b1101, {32'h00000000, 4'b1000}, "undef_op");
`ifndef ALU_MUL_EN
        do_op(32'h3, 32'h5, 4'b1100, {32'h00000000, 4'b1000}, "mul_disabled");
`endif

        // reset while a result is held
        in_valid = 1'b1; a = 32'd3; b = 32'd4; csig = 4'b0010; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_out", {out_valid, out, z, c, n, v}, '0);
        chk("rst_in_ready", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_release_ready", in_ready, 1'b1);
        tick();

        // back-pressure then a same-edge replace
        in_valid = 1'b1; a = 32'd1; b = 32'd2; csig = 4'b0010; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; a = $urandom; b = $urandom;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", {out_valid, in_ready, out}, {1'b1, 1'b0, 32'd3});
            tick();
        end
        out_ready = 1'b1; in_valid = 1'b1; a = 32'd4; b = 32'd8; csig = 4'b0001;
        #1;
        chk("bp_ready", in_ready, 1'b1);
        tick();
        chk("bp_replace", {out_valid, out}, {1'b1, 32'd12});
        in_valid = 1'b0;
        tick();

`ifdef ALU_MUL_EN
        begin
            int edges;
            bit seen;
            in_valid = 1'b1; a = 32'h00010000; b = 32'h00010001; csig = 4'b1100; out_ready = 1'b1;
            #1;
            chk("mul_ready", in_ready, 1'b1);
            tick();
            in_valid = 1'b0; a = $urandom; b = $urandom; csig = 4'b0010;
            edges = 0;
            while (!out_valid && edges < 80) begin
                chk("mul_busy_ready", in_ready, 1'b0);
                tick();
                edges++;
            end
            chk("mul_latency", edges, 33);
            chk("mul_result", {out, z, c, n, v}, {32'h00010000, 4'b0100});
            tick();
            in_valid = 1'b1; a = 32'h1234; b = 32'h5678; csig = 4'b1100;
            tick();
            in_valid = 1'b0;
            for (int i = 0; i < 10; i++) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                seen |= out_valid;
                tick();
            end
            chk("mul_rst_no_pulse", seen, 1'b0);
            do_op(32'd2, 32'd3, 4'b0010, {32'd5, 4'b0000}, "add_after_mul_rst");
        end
`endif

        // randomized traffic; the compare process checks every cycle
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            csig      = ops[$urandom_range(0, 15)];
            case ($urandom_range(0, 5))
                0:       a = 32'h7FFFFFFF;
                1:       a = 32'h80000000;
                2:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'h1;
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            tick();
        end

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
